row_packer_float32: RTL and testbench

Stream-to-row packer that feeds `paralel_sum_float32`. It accepts IEEE-754 float32 words one per cycle over a valid/ready stream and assembles them into a packed row of `NUMBER_OF_INPUTS` lanes. The row is presented on a valid/ready output whose data bus matches the summer's `data_i`. A short row, terminated by `s_last_i`, is padded with +0.0 so the downstream sum is unaffected.

---
 rtl/row_packer_float32.sv | 83 ++++++++
 tb/tb_row_packer_float32.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_packer_float32.sv
// Stream-to-row packer: collects float32 words from a valid/ready stream into one
// N-lane row and holds it for the parallel summer. Rows closed early are zero-padded.
module row_packer_float32 #(
  parameter int NUMBER_OF_INPUTS = 8,
  parameter int BITS_PER_SYMBOL  = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n,
  input  logic [BITS_PER_SYMBOL-1:0]                  s_data_i,
  input  logic                                        s_valid_i,
  input  logic                                        s_last_i,
  output logic                                        s_ready_o,
  output logic [NUMBER_OF_INPUTS*BITS_PER_SYMBOL-1:0] m_data_o,
  output logic                                        m_valid_o,
  input  logic                                        m_ready_i,
  output logic [$clog2(NUMBER_OF_INPUTS+1)-1:0]       m_count_o,
  output logic                                        m_last_o
);

  localparam int N    = NUMBER_OF_INPUTS;
  localparam int IDXW = $clog2(N);
  localparam int CNTW = $clog2(N + 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                           state_q;
  logic [IDXW-1:0]                  idx_q;
  logic [N-1:0][BITS_PER_SYMBOL-1:0] row_q;

  assign m_data_o = row_q;

  // Clearing the row on handoff is what provides the +0.0 padding for short rows,
  // so lanes above the fill index never carry words from an older row.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      row_q     <= '0;
      m_count_o <= '0;
      m_last_o  <= 1'b0;
      s_ready_o <= 1'b1;
      m_valid_o <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid_i) begin
            row_q[idx_q] <= s_data_i;
            if ((idx_q == IDXW'(N - 1)) || s_last_i) begin
              m_count_o <= CNTW'(idx_q) + CNTW'(1);
              m_last_o  <= s_last_i;
              idx_q     <= '0;
              state_q   <= HOLD;
              s_ready_o <= 1'b0;
              m_valid_o <= 1'b1;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (m_ready_i) begin
            row_q     <= '0;
            m_count_o <= '0;
            m_last_o  <= 1'b0;
            idx_q     <= '0;
            state_q   <= FILL;
            s_ready_o <= 1'b1;
            m_valid_o <= 1'b0;
          end
        end
        default: begin
          state_q   <= FILL;
          s_ready_o <= 1'b1;
          m_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_packer_float32.sv
// Self-checking bench for row_packer_float32 (N=8): table vectors, hand-written
// corner sequences and a randomized run checked against a row-chunking model.
module tb_row_packer_float32;

  localparam int N = 8;
  localparam int W = N * 32;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i = 1'b0;
  logic          s_ready_o;
  logic [W-1:0]  m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [3:0]    m_count_o;
  logic          m_last_o;

  int checks = 0;
  int errors = 0;

  row_packer_float32 #(.NUMBER_OF_INPUTS(N), .BITS_PER_SYMBOL(32)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_last_i  (s_last_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_count_o (m_count_o),
    .m_last_o  (m_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int              nwords;
    logic [N-1:0][31:0] words;
    logic            last_flag;
    int              gap;
    logic [W-1:0]    exp_data;
    int              exp_count;
    logic            exp_last;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    int           count;
    logic         last;
  } row_t;

  vec_t vecs [3];
  row_t exp_q [$];

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one word and wait (bounded) until it is accepted on a clock edge.
  task automatic send_word(input logic [31:0] data, input logic last);
    int waited = 0;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_last_i  = last;
    while (!s_ready_o && waited < 100) begin
      cycle();
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_word_timeout: got s_ready_o=0 expected 1 within 100 cycles");
    end
    cycle();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.nwords; i++) begin
      send_word(v.words[i], v.last_flag && (i == v.nwords - 1));
      if (i != v.nwords - 1)
        repeat (v.gap) cycle();
    end
  endtask

  initial begin
    logic [W-1:0] held_data;
    logic [3:0]   held_count;
    logic         held_last;
    logic [31:0]  words [$];
    logic         lasts [$];
    row_t         cur;
    row_t         got;
    int           fill;
    int           widx;
    int           budget;
    logic         presenting;
    logic         prev_hold;
    logic         acc;

    // Table: full row of 1.0, short row with last, and last on lane 7 with gaps.
    vecs[0].nwords = 8; vecs[0].last_flag = 1'b0; vecs[0].gap = 0;
    vecs[0].words  = {8{32'h3F80_0000}};
    vecs[0].exp_data = {8{32'h3F80_0000}}; vecs[0].exp_count = 8; vecs[0].exp_last = 1'b0;

    vecs[1].nwords = 3; vecs[1].last_flag = 1'b1; vecs[1].gap = 0;
    vecs[1].words  = {{5{32'h0}}, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    vecs[1].exp_data = {{5{32'h0}}, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    vecs[1].exp_count = 3; vecs[1].exp_last = 1'b1;

    vecs[2].nwords = 8; vecs[2].last_flag = 1'b1; vecs[2].gap = 2;
    vecs[2].words  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[2].exp_data = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[2].exp_count = 8; vecs[2].exp_last = 1'b1;

    // Reset pulse, then idle.
    #12;
    rst_n = 1'b1;
    cycle();
    checkOutput("reset_m_valid", W'(m_valid_o), W'(0));
    checkOutput("reset_m_data",  m_data_o,      W'(0));
    checkOutput("reset_m_count", W'(m_count_o), W'(0));
    checkOutput("reset_m_last",  W'(m_last_o),  W'(0));
    checkOutput("reset_s_ready", W'(s_ready_o), W'(1));

    m_ready_i = 1'b1;
    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v]);
      checkOutput($sformatf("vec%0d_m_valid", v), W'(m_valid_o), W'(1));
      checkOutput($sformatf("vec%0d_s_ready_hold", v), W'(s_ready_o), W'(0));
      checkOutput($sformatf("vec%0d_m_data", v), m_data_o, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_m_count", v), W'(m_count_o), W'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d_m_last", v), W'(m_last_o), W'(vecs[v].exp_last));
      cycle();
      checkOutput($sformatf("vec%0d_m_valid_after", v), W'(m_valid_o), W'(0));
      checkOutput($sformatf("vec%0d_s_ready_after", v), W'(s_ready_o), W'(1));
    end

    // Backpressure: hold a one-word row while the source keeps offering 1.0.
    m_ready_i = 1'b0;
    send_word(32'h4040_0000, 1'b1);
    s_valid_i = 1'b1;
    s_data_i  = 32'h3F80_0000;
    s_last_i  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_m_valid", c), W'(m_valid_o), W'(1));
      checkOutput($sformatf("bp%0d_s_ready", c), W'(s_ready_o), W'(0));
      checkOutput($sformatf("bp%0d_m_data", c), m_data_o, W'(32'h4040_0000));
      checkOutput($sformatf("bp%0d_m_count", c), W'(m_count_o), W'(1));
      checkOutput($sformatf("bp%0d_m_last", c), W'(m_last_o), W'(1));
      cycle();
    end
    m_ready_i = 1'b1;
    cycle();
    checkOutput("bp_handoff_m_valid", W'(m_valid_o), W'(0));
    checkOutput("bp_handoff_s_ready", W'(s_ready_o), W'(1));
    cycle();
    send_word(32'h4000_0000, 1'b1);
    checkOutput("bp_next_m_data", m_data_o, {{6{32'h0}}, 32'h4000_0000, 32'h3F80_0000});
    checkOutput("bp_next_m_count", W'(m_count_o), W'(2));
    cycle();

    // Reset mid-row discards four accepted words.
    for (int i = 0; i < 4; i++) send_word(32'h4000_0000, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checkOutput("midrst_m_data", m_data_o, W'(0));
    checkOutput("midrst_m_valid", W'(m_valid_o), W'(0));
    cycle();
    send_word(32'h4040_0000, 1'b1);
    checkOutput("midrst_row_data", m_data_o, W'(32'h4040_0000));
    checkOutput("midrst_row_count", W'(m_count_o), W'(1));
    checkOutput("midrst_row_last", W'(m_last_o), W'(1));
    cycle();

    // Randomized run: model splits the word stream into rows of up to N words.
    for (int i = 0; i < 80; i++) begin
      words.push_back($urandom());
      lasts.push_back(($urandom_range(0, 5) == 0) || (i == 79));
    end
    cur.data = '0; cur.count = 0; cur.last = 1'b0;
    fill = 0;
    for (int i = 0; i < words.size(); i++) begin
      cur.data[fill*32 +: 32] = words[i];
      fill++;
      if (fill == N || lasts[i]) begin
        cur.count = fill;
        cur.last  = lasts[i];
        exp_q.push_back(cur);
        cur.data = '0;
        fill = 0;
      end
    end

    widx = 0; budget = 0; presenting = 1'b0; prev_hold = 1'b0;
    held_data = '0; held_count = '0; held_last = 1'b0;
    while (exp_q.size() > 0 && budget < 5000) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      if (!presenting && widx < words.size() && $urandom_range(0, 3) != 0)
        presenting = 1'b1;
      s_valid_i = presenting;
      s_data_i  = presenting ? words[widx] : 32'h0;
      s_last_i  = presenting ? lasts[widx] : 1'b0;

      if (prev_hold) begin
        checkOutput("rnd_hold_data", m_data_o, held_data);
        checkOutput("rnd_hold_count", W'(m_count_o), W'(held_count));
        checkOutput("rnd_hold_last", W'(m_last_o), W'(held_last));
      end
      checkOutput("rnd_ready_vs_valid", W'(s_ready_o), W'(!m_valid_o));
      if (m_valid_o && m_ready_i) begin
        got = exp_q.pop_front();
        checkOutput("rnd_row_data", m_data_o, got.data);
        checkOutput("rnd_row_count", W'(m_count_o), W'(got.count));
        checkOutput("rnd_row_last", W'(m_last_o), W'(got.last));
      end
      prev_hold  = m_valid_o && !m_ready_i;
      held_data  = m_data_o;
      held_count = m_count_o;
      held_last  = m_last_o;
      acc = s_valid_i && s_ready_o;
      cycle();
      if (acc) begin
        widx++;
        presenting = 1'b0;
      end
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rnd_timeout: got %0d rows outstanding expected 0", exp_q.size());
    end
    s_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
